// File: rtl/regfile_pkg.sv
// Shared defaults, helper and register-index names for the 2-read/1-write
// register file and its read ports.
package regfile_pkg;

  localparam int RF_N_DEF        = 64;
  localparam int RF_SEL_W_DEF    = 5;
  localparam int RF_ZERO_IDX_DEF = 31;

  // Architectural names for a few well-known register indices.
  typedef enum logic [RF_SEL_W_DEF-1:0] {
    REG_X0  = 5'd0,
    REG_X1  = 5'd1,
    REG_FP  = 5'd29,
    REG_LR  = 5'd30,
    REG_XZR = 5'd31
  } reg_idx_e;

  // Number of registers addressed by a select of the given width.
  function automatic int rf_depth(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port of the register file: full-depth select over the flattened
// storage, zero-register forcing, write-to-read bypass and an optional
// output register.
//
// Ports
//   clock_i     rising-edge clock
//   reset_i     synchronous active-high reset (clears the output register)
//   we_i        write enable of the shared write port
//   wa_i        write select
//   wd_i        write data
//   sel_i       read select for this port
//   mem_flat_i  storage contents, register k at bits [k*N +: N]
//   rd_o        read data
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int N        = RF_N_DEF,
  parameter int SEL_W    = RF_SEL_W_DEF,
  parameter bit ZERO_EN  = 1'b1,
  parameter int ZERO_IDX = RF_ZERO_IDX_DEF,
  parameter bit BYPASS   = 1'b1,
  parameter bit READ_REG = 1'b0
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         we_i,
  input  logic [SEL_W-1:0]             wa_i,
  input  logic [N-1:0]                 wd_i,
  input  logic [SEL_W-1:0]             sel_i,
  input  logic [rf_depth(SEL_W)*N-1:0] mem_flat_i,
  output logic [N-1:0]                 rd_o
);

  localparam int              DEPTH    = rf_depth(SEL_W);
  localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(ZERO_IDX);

  logic [N-1:0] words [DEPTH];
  logic [N-1:0] rd_d;
  logic [N-1:0] rd_q;
  logic         is_zero;
  logic         is_bypass;

  for (genvar g = 0; g < DEPTH; g++) begin : g_words
    assign words[g] = mem_flat_i[g*N +: N];
  end

  assign is_zero   = ZERO_EN && (sel_i == ZERO_SEL);
  // A write that reset is about to discard must not be forwarded.
  assign is_bypass = BYPASS && we_i && !reset_i && (wa_i == sel_i);

  always_comb begin
    rd_d = words[sel_i];
    if (is_zero) begin
      rd_d = '0;
    end else if (is_bypass) begin
      rd_d = wd_i;
    end
  end

  // Always present; with READ_REG=0 nothing observes it and it is trimmed.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_o = READ_REG ? rd_q : rd_d;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with 2**SEL_W entries of N bits, one write port and two
// independent read ports (A, B). Optional hardwired zero register,
// write-to-read bypass and registered-read mode.
//
// Ports
//   clock  rising-edge clock
//   reset  synchronous active-high reset; clears every register and
//          dominates a simultaneous write
//   WE     write enable
//   WA     write select
//   WD     write data
//   SA     read select, port A
//   SB     read select, port B
//   A      read data, port A
//   B      read data, port B
module reg_file_2r1w
  import regfile_pkg::*;
#(
  parameter int N        = RF_N_DEF,
  parameter int SEL_W    = RF_SEL_W_DEF,
  parameter bit ZERO_EN  = 1'b1,
  parameter int ZERO_IDX = RF_ZERO_IDX_DEF,
  parameter bit BYPASS   = 1'b1,
  parameter bit READ_REG = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             WE,
  input  logic [SEL_W-1:0] WA,
  input  logic [N-1:0]     WD,
  input  logic [SEL_W-1:0] SA,
  input  logic [SEL_W-1:0] SB,
  output logic [N-1:0]     A,
  output logic [N-1:0]     B
);

  localparam int               DEPTH    = rf_depth(SEL_W);
  localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(ZERO_IDX);

  logic [N-1:0]       mem_q [DEPTH];
  logic [DEPTH*N-1:0] mem_flat;
  logic               wr_en;

  // Writes to the zero register are dropped so its storage stays 0.
  assign wr_en = WE && !(ZERO_EN && (WA == ZERO_SEL));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[WA] <= WD;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*N +: N] = mem_q[g];
  end

  regfile_read_port #(
    .N        (N),
    .SEL_W    (SEL_W),
    .ZERO_EN  (ZERO_EN),
    .ZERO_IDX (ZERO_IDX),
    .BYPASS   (BYPASS),
    .READ_REG (READ_REG)
  ) u_port_a (
    .clock_i    (clock),
    .reset_i    (reset),
    .we_i       (WE),
    .wa_i       (WA),
    .wd_i       (WD),
    .sel_i      (SA),
    .mem_flat_i (mem_flat),
    .rd_o       (A)
  );

  regfile_read_port #(
    .N        (N),
    .SEL_W    (SEL_W),
    .ZERO_EN  (ZERO_EN),
    .ZERO_IDX (ZERO_IDX),
    .BYPASS   (BYPASS),
    .READ_REG (READ_REG)
  ) u_port_b (
    .clock_i    (clock),
    .reset_i    (reset),
    .we_i       (WE),
    .wa_i       (WA),
    .wd_i       (WD),
    .sel_i      (SB),
    .mem_flat_i (mem_flat),
    .rd_o       (B)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w. Eight instances cover every combination of
// ZERO_EN (cfg bit 0), BYPASS (cfg bit 1) and READ_REG (cfg bit 2), all fed
// the same stimulus. Expected read data is pushed to a scoreboard when the
// stimulus is driven and compared when each instance produces it.
module tb_reg_file_2r1w;

  localparam int N    = 64;
  localparam int SW   = 5;
  localparam int NCFG = 8;
  localparam int ZIDX = 31;

  typedef struct {
    int          cfg;
    int          due;
    logic [63:0] ea;
    logic [63:0] eb;
  } exp_t;

  logic          clock = 1'b0;
  logic          rst_r;
  logic          we_r;
  logic [SW-1:0] wa_r;
  logic [SW-1:0] sa_r;
  logic [SW-1:0] sb_r;
  logic [N-1:0]  wd_r;
  logic [N-1:0]  a_o [NCFG];
  logic [N-1:0]  b_o [NCFG];

  logic [N-1:0]  mem_m [NCFG][32];
  exp_t          sb_q [$];
  int            ncyc = 0;
  bit            sb_en = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    reg_file_2r1w #(
      .N        (N),
      .SEL_W    (SW),
      .ZERO_EN  ((g & 1) != 0),
      .ZERO_IDX (ZIDX),
      .BYPASS   ((g & 2) != 0),
      .READ_REG ((g & 4) != 0)
    ) u_dut (
      .clock (clock),
      .reset (rst_r),
      .WE    (we_r),
      .WA    (wa_r),
      .WD    (wd_r),
      .SA    (sa_r),
      .SB    (sb_r),
      .A     (a_o[g]),
      .B     (b_o[g])
    );
  end

  function automatic bit cfg_ze(input int c);
    return (c & 1) != 0;
  endfunction

  function automatic bit cfg_bp(input int c);
    return (c & 2) != 0;
  endfunction

  function automatic bit cfg_rr(input int c);
    return (c & 4) != 0;
  endfunction

  // Reference read selection against the model storage and current inputs.
  function automatic logic [63:0] model_sel(input int c, input logic [SW-1:0] s);
    if (cfg_ze(c) && s == SW'(ZIDX)) return '0;
    if (cfg_bp(c) && we_r && !rst_r && wa_r == s) return wd_r;
    return mem_m[c][s];
  endfunction

  function automatic logic [SW-1:0] rnd_sel();
    int r;
    r = $urandom_range(0, 7);
    if (r < 3) return SW'($urandom_range(0, 3));
    if (r == 3) return SW'(ZIDX);
    return SW'($urandom_range(0, 31));
  endfunction

  // Apply inputs for one cycle and push what each instance should show.
  task automatic drive(input logic rst, input logic we, input logic [SW-1:0] wa,
                       input logic [N-1:0] wd, input logic [SW-1:0] sa,
                       input logic [SW-1:0] sb);
    exp_t e;
    rst_r = rst;
    we_r  = we;
    wa_r  = wa;
    wd_r  = wd;
    sa_r  = sa;
    sb_r  = sb;
    if (sb_en) begin
      for (int c = 0; c < NCFG; c++) begin
        if (!cfg_rr(c)) begin
          e.cfg = c;
          e.due = ncyc;
          e.ea  = model_sel(c, sa);
          e.eb  = model_sel(c, sb);
          sb_q.push_back(e);
        end
      end
      for (int c = 0; c < NCFG; c++) begin
        if (cfg_rr(c)) begin
          e.cfg = c;
          e.due = ncyc + 1;
          e.ea  = rst ? '0 : model_sel(c, sa);
          e.eb  = rst ? '0 : model_sel(c, sb);
          sb_q.push_back(e);
        end
      end
    end
  endtask

  // Drain due scoreboard entries at the falling edge, then advance past the
  // rising edge and update the reference storage.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    while (sb_q.size() > 0 && sb_q[0].due <= ncyc) begin
      e = sb_q.pop_front();
      vectors++;
      if (a_o[e.cfg] !== e.ea || b_o[e.cfg] !== e.eb) begin
        miscompares++;
        $display("FAIL scoreboard cfg=%0d cyc=%0d A=%h exp=%h B=%h exp=%h",
                 e.cfg, ncyc, a_o[e.cfg], e.ea, b_o[e.cfg], e.eb);
      end
    end
    ncyc++;
    @(posedge clock);
    for (int c = 0; c < NCFG; c++) begin
      if (rst_r) begin
        for (int i = 0; i < 32; i++) mem_m[c][i] = '0;
      end else if (we_r && !(cfg_ze(c) && wa_r == SW'(ZIDX))) begin
        mem_m[c][wa_r] = wd_r;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, SW'(i), {$urandom, $urandom} | 64'h1, rnd_sel(), rnd_sel());
      tick();
    end
    drive(1'b1, 1'b0, '0, '0, '0, '0);
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, '0, '0, SW'(i), SW'(31 - i));
      #3;
      for (int c = 0; c < NCFG; c++) begin
        vectors++;
        if (a_o[c] !== '0 || b_o[c] !== '0) begin
          miscompares++;
          $display("FAIL reset_sweep cfg=%0d sel=%0d A=%h B=%h expected 0", c, i, a_o[c], b_o[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_write();
    drive(1'b0, 1'b1, 5'd5, 64'h0123456789ABCDEF, '0, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 5'd5, 5'd6);
    #3;
    for (int c = 0; c < NCFG; c++) begin
      if (!cfg_rr(c)) begin
        vectors++;
        if (a_o[c] !== 64'h0123456789ABCDEF || b_o[c] !== '0) begin
          miscompares++;
          $display("FAIL write_read cfg=%0d A=%h B=%h expected 0123456789abcdef/0", c, a_o[c], b_o[c]);
        end
      end
    end
    tick();
    for (int c = 0; c < NCFG; c++) begin
      if (cfg_rr(c)) begin
        vectors++;
        if (a_o[c] !== 64'h0123456789ABCDEF || b_o[c] !== '0) begin
          miscompares++;
          $display("FAIL write_read_reg cfg=%0d A=%h B=%h expected 0123456789abcdef/0", c, a_o[c], b_o[c]);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [63:0] exp_v;
    drive(1'b0, 1'b1, SW'(ZIDX), '1, SW'(ZIDX), SW'(ZIDX));
    #3;
    for (int c = 0; c < NCFG; c++) begin
      if (!cfg_rr(c) && cfg_ze(c)) begin
        vectors++;
        if (a_o[c] !== '0 || b_o[c] !== '0) begin
          miscompares++;
          $display("FAIL zero_same_cycle cfg=%0d A=%h B=%h expected 0", c, a_o[c], b_o[c]);
        end
      end
    end
    tick();
    drive(1'b0, 1'b0, '0, '0, SW'(ZIDX), SW'(ZIDX));
    #3;
    for (int c = 0; c < NCFG; c++) begin
      if (!cfg_rr(c)) begin
        exp_v = cfg_ze(c) ? 64'h0 : '1;
        vectors++;
        if (a_o[c] !== exp_v || b_o[c] !== exp_v) begin
          miscompares++;
          $display("FAIL zero_after cfg=%0d A=%h B=%h expected %h", c, a_o[c], b_o[c], exp_v);
        end
      end
    end
    tick();
    for (int c = 0; c < NCFG; c++) begin
      if (cfg_rr(c)) begin
        exp_v = cfg_ze(c) ? 64'h0 : '1;
        vectors++;
        if (a_o[c] !== exp_v || b_o[c] !== exp_v) begin
          miscompares++;
          $display("FAIL zero_after_reg cfg=%0d A=%h B=%h expected %h", c, a_o[c], b_o[c], exp_v);
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [63:0] exp_v;
    drive(1'b0, 1'b1, 5'd7, 64'hAA, '0, '0);
    tick();
    drive(1'b0, 1'b1, 5'd7, 64'h55, 5'd7, 5'd7);
    #3;
    for (int c = 0; c < NCFG; c++) begin
      if (!cfg_rr(c)) begin
        exp_v = cfg_bp(c) ? 64'h55 : 64'hAA;
        vectors++;
        if (a_o[c] !== exp_v || b_o[c] !== exp_v) begin
          miscompares++;
          $display("FAIL bypass_same_cycle cfg=%0d A=%h B=%h expected %h", c, a_o[c], b_o[c], exp_v);
        end
      end
    end
    tick();
    drive(1'b0, 1'b0, '0, '0, 5'd7, 5'd7);
    #3;
    for (int c = 0; c < NCFG; c++) begin
      if (!cfg_rr(c)) begin
        vectors++;
        if (a_o[c] !== 64'h55 || b_o[c] !== 64'h55) begin
          miscompares++;
          $display("FAIL bypass_after cfg=%0d A=%h B=%h expected 55", c, a_o[c], b_o[c]);
        end
      end
    end
    tick();
  endtask

  task automatic test_read_reg();
    logic [63:0] exp_v;
    drive(1'b0, 1'b1, 5'd3, 64'h11, '0, '0);
    tick();
    drive(1'b0, 1'b1, 5'd3, 64'h22, 5'd3, 5'd3);
    tick();
    for (int c = 0; c < NCFG; c++) begin
      if (cfg_rr(c)) begin
        exp_v = cfg_bp(c) ? 64'h22 : 64'h11;
        vectors++;
        if (a_o[c] !== exp_v) begin
          miscompares++;
          $display("FAIL read_reg_edge cfg=%0d A=%h expected %h", c, a_o[c], exp_v);
        end
      end
    end
    drive(1'b0, 1'b0, '0, '0, 5'd3, 5'd3);
    tick();
    for (int c = 0; c < NCFG; c++) begin
      if (cfg_rr(c)) begin
        vectors++;
        if (a_o[c] !== 64'h22) begin
          miscompares++;
          $display("FAIL read_reg_settled cfg=%0d A=%h expected 22", c, a_o[c]);
        end
      end
    end
    drive(1'b1, 1'b0, '0, '0, 5'd3, 5'd3);
    tick();
    for (int c = 0; c < NCFG; c++) begin
      if (cfg_rr(c)) begin
        vectors++;
        if (a_o[c] !== '0 || b_o[c] !== '0) begin
          miscompares++;
          $display("FAIL read_reg_reset cfg=%0d A=%h B=%h expected 0", c, a_o[c], b_o[c]);
        end
      end
    end
  endtask

  task automatic test_reset_vs_write();
    drive(1'b0, 1'b1, 5'd2, 64'h77, '0, '0);
    tick();
    drive(1'b1, 1'b1, 5'd2, 64'h99, 5'd2, 5'd2);
    tick();
    drive(1'b0, 1'b0, '0, '0, 5'd2, 5'd2);
    #3;
    for (int c = 0; c < NCFG; c++) begin
      if (!cfg_rr(c)) begin
        vectors++;
        if (a_o[c] !== '0) begin
          miscompares++;
          $display("FAIL reset_dominates cfg=%0d A=%h expected 0", c, a_o[c]);
        end
      end
    end
    tick();
    for (int c = 0; c < NCFG; c++) begin
      if (cfg_rr(c)) begin
        vectors++;
        if (a_o[c] !== '0) begin
          miscompares++;
          $display("FAIL reset_dominates_reg cfg=%0d A=%h expected 0", c, a_o[c]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
    for (int i = 0; i < 2000; i++) begin
      sa = rnd_sel();
      sb = ($urandom_range(0, 1) == 0) ? sa : rnd_sel();
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 2) != 0, rnd_sel(),
            {$urandom, $urandom}, sa, sb);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired at cycle %0d", ncyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_r = 1'b1;
    we_r  = 1'b0;
    wa_r  = '0;
    wd_r  = '0;
    sa_r  = '0;
    sb_r  = '0;
    @(posedge clock);
    #1;
    drive(1'b1, 1'b0, '0, '0, '0, '0);
    tick();
    sb_en = 1'b1;
    test_reset();
    test_write();
    test_zero_reg();
    test_bypass();
    test_read_reg();
    test_reset_vs_write();
    test_random();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
